dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the core's data memory (byte/halfword/word load-store unit over a 1R1W word SRAM). It shares the single memory port between port 0 (core load/store unit) and port 1 (debug/loader). It uses valid/ready request and response handshakes, rejects misaligned or reserved-size accesses without touching memory, and holds each response until the requester accepts it. At most one transaction is outstanding at a time.

## Interface
- ADDR_W, 32: byte-address width on all ports.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req_valid / p1_req_valid  in  1  request present.
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle.
- p0_req_addr / p1_req_addr  in  ADDR_W  byte address.
- p0_req_we / p1_req_we  in  1  1 = store, 0 = load.
- p0_req_wdata / p1_req_wdata  in  32  store data, right-aligned.
- p0_req_size / p1_req_size  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 reserved; [2]: unsigned load.
- p0_rsp_valid / p1_rsp_valid  out  1  response present.
- p0_rsp_ready / p1_rsp_ready  in  1  response accepted.
- p0_rsp_rdata / p1_rsp_rdata  out  32  load data, already extended by the memory block; 0 for stores and errors.
- p0_rsp_err / p1_rsp_err  out  1  misaligned or reserved-size access.
- mem_rd_addr, mem_wr_addr  out  ADDR_W  byte address to the memory.
- mem_wr_din  out  32  store data.
- mem_we  out  1  single-cycle write strobe.
- mem_wr_strb  out  3  size code forwarded unchanged.
- mem_rd_dout  in  32  load data, valid one cycle after the address is presented (registered read).

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- **IDLE**
  - Arbitrate the valid requests. Assert req_ready only for the winner.
  - On handshake, latch port id, addr, we, wdata and size.
  - If the request is erroneous, go to RESP with err=1 and no memory access. Otherwise go to ACCESS.
- **Error rules**
  - size[1:0]=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠00.
- **ACCESS**
  - Drive mem_rd_addr = mem_wr_addr = latched addr, mem_wr_strb = latched size, mem_wr_din = latched wdata.
  - mem_we = latched we, for this cycle only.
  - Go to CAPTURE.
- **CAPTURE**
  - Register mem_rd_dout into the response data if the access is a load; otherwise register 0.
  - Go to RESP.
- **RESP**
  - Assert rsp_valid on the owning port only.
  - On rsp_ready, go to IDLE.
  - rsp_rdata and rsp_err stay stable until the response is accepted.
- **Outside ACCESS**
  - mem_we=0.
  - Memory address and data outputs hold their last value (0 after reset).
- **Arbitration**
  - See Configuration.
  - The priority pointer updates only on a request handshake.
- **Port ownership**
  - The response is returned only to the port that issued the request.
  - The other port sees req_ready=0 until the FSM returns to IDLE.

## Timing
- Request handshake in cycle T:
  - mem_we/address driven in T+1.
  - rsp_valid first high in T+3.
- Erroneous request: rsp_valid high in T+1.
- RESP→IDLE on handshake cycle R. The next request can be accepted in R+1, so there is no back-to-back acceptance.
  - Peak throughput: 1 transaction per 4 cycles.
- Simultaneous valid requests: exactly one req_ready is high. The loser keeps its request valid and must not change it.
- A request asserted while the FSM is busy stays pending.
- Reset (asserted at any time, including mid-ACCESS):
  - State returns to IDLE and any pending response is dropped.
  - All outputs are 0: req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, addresses, wdata, strb.
  - The priority pointer favours port 0.
- req_ready is a combinational function of the state, the valid inputs and the pointer. It must not depend on rsp_ready.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin.
  - When both ports are valid, the port not granted last wins.
  - The first contention after reset goes to port 0.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. The pointer register is not instantiated.

## Test plan
- **Port-0 word store then load:**
  - p0 stores 0xDEADBEEF at addr 0x8.
  - Expect mem_we=1 exactly at T+1 with mem_wr_addr=0x8.
  - Expect rsp_valid at T+3 with rdata=0, err=0.
  - The following load of 0x8 returns 0xDEADBEEF at T+3.
- **Misaligned:**
  - p1 half load at addr 0x3 → p1_rsp_valid at T+1, err=1, rdata=0, and mem_we never asserted.
  - Repeat with size 11 at addr 0x4 for the same result.
- **Contention:**
  - Both ports valid every cycle for 4 transactions.
  - With RR_EN: grant order p0,p1,p0,p1.
  - Without RR_EN: p0,p0,p0,p0, and p1 never receives req_ready.
- **Response backpressure:**
  - Hold p0_rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_rdata stays stable throughout.
  - p1 req_ready stays 0 until one cycle after the p0 response handshake.
- **Reset mid-operation:**
  - Assert rst in the ACCESS cycle of a store.
  - All outputs go to 0 immediately, and no response is ever issued.
  - After release, a fresh p1 request completes normally with rsp_valid at T+3.
- **Byte signed load:**
  - Memory word 0x80FF7F01.
  - p0 byte load at addr 0x2, size 000 → rdata=0xFFFFFFFF.
  - Same load with size 100 → rdata=0x000000FF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and access sequencer in front of a 1R1W data-memory port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic              p0_req_we,
    input  logic [31:0]       p0_req_wdata,
    input  logic [2:0]        p0_req_size,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic              p1_req_we,
    input  logic [31:0]       p1_req_wdata,
    input  logic [2:0]        p1_req_size,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_din,
    output logic              mem_we,
    output logic [2:0]        mem_wr_strb,
    input  logic [31:0]       mem_rd_dout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [2:0]        mem_strb_q;
    logic              mem_we_q;

    logic              idle;
    logic              pick1;
    logic              grant0, grant1, hs;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_size;
    logic              req_err;
    logic              rsp_accept;

    assign idle = (state_q == ST_IDLE);

`ifdef DMEM_ARB_RR_EN
    // ptr_q set means port 1 is favoured on the next contention.
    logic ptr_q;

    assign pick1 = p1_req_valid & (~p0_req_valid | ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (hs) begin
            ptr_q <= ~pick1;
        end
    end
`else
    assign pick1 = p1_req_valid & ~p0_req_valid;
`endif

    assign grant1 = idle & pick1;
    assign grant0 = idle & p0_req_valid & ~pick1;
    assign hs     = grant0 | grant1;

    // Gating with rst only on the outputs keeps reset out of the flop data paths.
    assign p0_req_ready = grant0 & ~rst;
    assign p1_req_ready = grant1 & ~rst;

    assign sel_addr  = pick1 ? p1_req_addr  : p0_req_addr;
    assign sel_we    = pick1 ? p1_req_we    : p0_req_we;
    assign sel_wdata = pick1 ? p1_req_wdata : p0_req_wdata;
    assign sel_size  = pick1 ? p1_req_size  : p0_req_size;

    assign req_err = (sel_size[1:0] == 2'b11) ||
                     ((sel_size[1:0] == 2'b01) && sel_addr[0]) ||
                     ((sel_size[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));

    assign rsp_accept = owner_q ? p1_rsp_ready : p0_rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (hs) state_d = req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_accept) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;
            if (hs) begin
                owner_q <= pick1;
                we_q    <= sel_we;
                err_q   <= req_err;
                rdata_q <= '0;
                // Erroneous requests never reach memory, so its port keeps its old values.
                if (!req_err) begin
                    mem_addr_q  <= sel_addr;
                    mem_wdata_q <= sel_wdata;
                    mem_strb_q  <= sel_size;
                    mem_we_q    <= sel_we;
                end
            end
            if (state_q == ST_CAPTURE) begin
                rdata_q <= we_q ? 32'h0 : mem_rd_dout;
            end
        end
    end

    assign mem_rd_addr = mem_addr_q;
    assign mem_wr_addr = mem_addr_q;
    assign mem_wr_din  = mem_wdata_q;
    assign mem_wr_strb = mem_strb_q;
    assign mem_we      = mem_we_q;

    assign p0_rsp_valid = (state_q == ST_RESP) & ~owner_q;
    assign p1_rsp_valid = (state_q == ST_RESP) &  owner_q;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : 32'h0;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : 32'h0;
    assign p0_rsp_err   = p0_rsp_valid & err_q;
    assign p1_rsp_err   = p1_rsp_valid & err_q;

endmodule
